// File: rtl/ks_pkg.sv
// ks_pkg: shared definitions for the iterative Kogge-Stone adder controller.
//   KS_W        default operand width
//   ks_state_e  controller state encoding
//   ks_cnt_w()  width of the prefix-iteration counter for a given LOG2W
package ks_pkg;

  localparam int unsigned KS_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    POST   = 2'd2,
    DONE   = 2'd3
  } ks_state_e;

  // Counter must hold 0..n-1; at least one bit even when n == 1.
  function automatic int unsigned ks_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned KS_CNT_W = ks_cnt_w($clog2(KS_W));

endpackage

// File: rtl/ks_dyn_stage.sv
// ks_dyn_stage: one Kogge-Stone prefix stage with a runtime-selected distance.
//   i_g, i_p  [W]      current generate / propagate vectors
//   i_idx     [CNT_W]  stage index; distance d = 1 << i_idx
//   o_g, o_p  [W]      vectors after the stage (bits below d pass through)
module ks_dyn_stage
  import ks_pkg::*;
#(
  parameter int unsigned W     = KS_W,
  parameter int unsigned CNT_W = KS_CNT_W
) (
  input  logic [W-1:0]     i_g,
  input  logic [W-1:0]     i_p,
  input  logic [CNT_W-1:0] i_idx,
  output logic [W-1:0]     o_g,
  output logic [W-1:0]     o_p
);

  localparam int unsigned LOG2W = $clog2(W);

  logic [LOG2W-1:0] w_dist;
  logic [W-1:0]     w_g_sh;
  logic [W-1:0]     w_p_sh;
  logic [W-1:0]     w_low_mask;

  assign w_dist     = LOG2W'(1) << i_idx;
  // Shifted-in zeros make the black cell a no-op on G for bits below d.
  assign w_g_sh     = i_g << w_dist;
  assign w_p_sh     = i_p << w_dist;
  // P must be held (not cleared) for bits below d, hence the mask.
  assign w_low_mask = ~({W{1'b1}} << w_dist);

  // Black cell per bit; grey behaviour falls out for the pass-through bits.
  assign o_g = i_g | (i_p & w_g_sh);
  assign o_p = i_p & (w_p_sh | w_low_mask);

endmodule

// File: rtl/ks_iter_ctrl.sv
// ks_iter_ctrl: sequential Kogge-Stone adder reusing one prefix stage for
// LOG2W cycles. Valid/ready handshake on operand and result sides.
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid/o_ready       operand handshake (o_ready high only in IDLE)
//   i_a, i_b, i_c0        operands and carry-in
//   o_valid/i_ready       result handshake
//   o_sum, o_cout         registered sum and carry-out
//   o_busy                high whenever the controller is not IDLE
//   o_ovf                 signed overflow; present only with KS_ITER_OVF_EN
module ks_iter_ctrl
  import ks_pkg::*;
#(
  parameter int unsigned W = KS_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_c0,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_busy
`ifdef KS_ITER_OVF_EN
  ,
  output logic         o_ovf
`endif
);

  localparam int unsigned LOG2W = $clog2(W);
  localparam int unsigned CNT_W = ks_cnt_w(LOG2W);

  ks_state_e        r_state;
  logic [W-1:0]     r_g;
  logic [W-1:0]     r_p;
  logic [W-1:0]     r_psave;
  logic             r_c0;
  logic [CNT_W-1:0] r_cnt;
  logic             r_valid;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_busy;

  logic [W-1:0]     w_g_init;
  logic [W-1:0]     w_g_nxt;
  logic [W-1:0]     w_p_nxt;

  // Carry-in folded into bit 0 so G[i] becomes the true carry out of bit i.
  always_comb begin
    w_g_init    = i_a & i_b;
    w_g_init[0] = (i_a[0] & i_b[0]) | ((i_a[0] ^ i_b[0]) & i_c0);
  end

  ks_dyn_stage #(
    .W     (W),
    .CNT_W (CNT_W)
  ) u_stage (
    .i_g   (r_g),
    .i_p   (r_p),
    .i_idx (r_cnt),
    .o_g   (w_g_nxt),
    .o_p   (w_p_nxt)
  );

`ifdef KS_ITER_OVF_EN
  logic r_ovf;
`endif

  // Controller FSM with datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_g     <= '0;
      r_p     <= '0;
      r_psave <= '0;
      r_c0    <= 1'b0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef KS_ITER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_g     <= w_g_init;
            r_p     <= i_a ^ i_b;
            r_psave <= i_a ^ i_b;
            r_c0    <= i_c0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= PREFIX;
          end
        end
        PREFIX: begin
          r_g   <= w_g_nxt;
          r_p   <= w_p_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(LOG2W - 1)) begin
            r_state <= POST;
          end
        end
        POST: begin
          r_sum   <= r_psave ^ {r_g[W-2:0], r_c0};
          r_cout  <= r_g[W-1];
`ifdef KS_ITER_OVF_EN
          r_ovf   <= r_g[W-1] ^ r_g[W-2];
`endif
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;
  assign o_busy  = r_busy;
`ifdef KS_ITER_OVF_EN
  assign o_ovf   = r_ovf;
`endif

endmodule
